// File: rtl/fifo_wr_rr_arbiter_pkg.sv
// rtl/fifo_wr_rr_arbiter_pkg.sv - shared types and widths for the FIFO write round-robin arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Largest supported BURST_MAX; the beat counter is sized to hold it.
  localparam int BURST_MAX_LIMIT = 256;
  localparam int BEAT_CNT_W      = $clog2(BURST_MAX_LIMIT + 1);

  // Width of a requester index; never narrower than one bit.
  function automatic int GRANT_W(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_rr_arbiter_if.sv
// rtl/fifo_wr_rr_arbiter_if.sv - requester and FIFO write-port bundle for the arbiter
interface fifo_wr_rr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int GW = GRANT_W(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      fifo_wr_en;
  logic                      fifo_wr_full;
  logic                      fifo_almost_full;
  logic [GW-1:0]             grant_id;
  logic                      busy;

  // Producers and the FIFO side drive the master view.
  modport master (
    output req_valid, req_data, req_last, fifo_wr_full, fifo_almost_full,
    input  req_ready, fifo_wr_data, fifo_wr_en, grant_id, busy
  );

  // The arbiter uses the slave view.
  modport slave (
    input  req_valid, req_data, req_last, fifo_wr_full, fifo_almost_full,
    output req_ready, fifo_wr_data, fifo_wr_en, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_rr_arbiter_rr_pick.sv
// rtl/fifo_wr_rr_arbiter_rr_pick.sv - first valid requester at or after a rotating pointer
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W:0]   sum;
  logic [W-1:0] cand;

  // Walk the requesters starting at ptr, wrapping modulo N; first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (W+1)'(k);
      if (sum >= (W+1)'(N)) begin
        sum = sum - (W+1)'(N);
      end
      cand = sum[W-1:0];
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// rtl/fifo_wr_rr_arbiter.sv - round-robin burst arbiter on a FIFO write port; FIFO_ARB_STATS_EN adds beat/stall counters
module fifo_wr_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_wr_rr_arbiter_if.slave   bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] stat_beats,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int GW = GRANT_W(NUM_REQ);
  localparam logic [BEAT_CNT_W-1:0] CNT_LAST = BEAT_CNT_W'(BURST_MAX - 1);

  arb_state_e              state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           ptr_q, ptr_d;
  logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;

  logic [DATA_W-1:0]       data_arr [NUM_REQ];
  logic                    throttle_ok;
  logic                    beat;
  logic                    burst_end;
  logic                    pick_found;
  logic [GW-1:0]           pick_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Ready goes only to the grantee, and only while the FIFO has headroom.
  always_comb begin
    throttle_ok   = !bus.fifo_almost_full && !bus.fifo_wr_full;
    bus.req_ready = '0;
    if (state_q == ARB_BURST && throttle_ok) begin
      bus.req_ready[grant_q] = 1'b1;
    end
    beat      = (state_q == ARB_BURST) && throttle_ok && bus.req_valid[grant_q];
    burst_end = beat && (bus.req_last[grant_q] || cnt_q == CNT_LAST);
  end

  // Grant selection, beat counting and the registered write stage.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_data_d = data_arr[grant_q];
          cnt_d     = cnt_q + 1'b1;
          if (burst_end) begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
            ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          end
        end
      end
    endcase
  end

  // State and output registers; reset drops any write still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = (state_q == ARB_BURST);

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] beats_q [NUM_REQ];
  logic [31:0] beats_d [NUM_REQ];
  logic [31:0] stall_q, stall_d;

  // Per-requester beat totals and FIFO-backpressure stall cycles, wrapping at 2^32.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      beats_d[i] = beats_q[i];
    end
    stall_d = stall_q;
    if (beat) begin
      beats_d[grant_q] = beats_q[grant_q] + 32'd1;
    end
    if (state_q == ARB_BURST && bus.req_valid[grant_q] && !throttle_ok) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        beats_q[i] <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        beats_q[i] <= beats_d[i];
      end
      stall_q <= stall_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    assign stat_beats[i*32 +: 32] = beats_q[i];
  end
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// tb/tb_fifo_wr_rr_arbiter.sv - self-checking bench for fifo_wr_rr_arbiter (FIFO_ARB_STATS_EN optional)
module tb_fifo_wr_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int BM = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [N*32-1:0] stat_beats;
  logic [31:0]     stall_cycles;
`endif

  fifo_wr_rr_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_beats   (stat_beats),
    .stall_cycles (stall_cycles)
`endif
  );

  int checks = 0;
  int passed = 0;

  // Per-requester word lists and the expected write stream / grant order.
  logic [W-1:0] mem_d [N][256];
  logic         mem_l [N][256];
  int           hd [N];
  int           tl [N];
  int           pops [N];
  logic [W-1:0] exp_d [$];
  int           exp_g [$];

  task automatic push_word(input int r, input logic [W-1:0] d, input logic l);
    mem_d[r][tl[r]] = d;
    mem_l[r][tl[r]] = l;
    tl[r]++;
  endtask

  task automatic load_seq(input int r, input int n, input int last_every);
    for (int k = 0; k < n; k++) begin
      push_word(r, $urandom, ((k + 1) % last_every == 0) || (k == n - 1));
    end
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.fifo_almost_full = 1'b0;
    bus.fifo_wr_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      pops[i] = 0;
    end
    exp_d.delete();
    exp_g.delete();
  endtask

  // Transaction-level model: rotate over requesters with data, each grant takes
  // words until a last flag or BM words, pointer moves past the grantee.
  task automatic build_model;
    int h [N];
    int ptr, sel, n, j;
    logic lst;
    for (int i = 0; i < N; i++) h[i] = hd[i];
    ptr = 0;
    for (int guard = 0; guard < 2000; guard++) begin
      sel = -1;
      for (int k = 0; k < N; k++) begin
        j = (ptr + k) % N;
        if (sel < 0 && h[j] < tl[j]) sel = j;
      end
      if (sel < 0) break;
      exp_g.push_back(sel);
      n = 0;
      lst = 1'b0;
      while (!lst && n < BM && h[sel] < tl[sel]) begin
        exp_d.push_back(mem_d[sel][h[sel]]);
        lst = mem_l[sel][h[sel]];
        h[sel]++;
        n++;
      end
      ptr = (sel + 1) % N;
    end
  endtask

  task automatic run_traffic(input int af_pct, input int full_pct, input int gap_pct,
                             input int af_at, input int af_len, input int budget);
    bit pend [N];
    bit any_pend, done, prev_busy, af_b, full_b, has, gap;
    int gi, cur_g, idle_run;
    logic [W-1:0] e;
    logic [N-1:0] rdy, vld;
    build_model();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    prev_busy = 1'b0;
    gi = 0;
    cur_g = -1;
    idle_run = 0;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      any_pend = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          hd[i]++;
          pops[i]++;
          any_pend = 1'b1;
        end
      end
      checks++;
      if (bus.fifo_wr_en !== any_pend)
        $display("FAIL wr_en cycle %0d: got %b want %b", c, bus.fifo_wr_en, any_pend);
      else passed++;
      if (any_pend) begin
        if (exp_d.size() > 0) e = exp_d.pop_front();
        else e = 'x;
        checks++;
        if (bus.fifo_wr_data !== e)
          $display("FAIL wr_data cycle %0d: got %h want %h", c, bus.fifo_wr_data, e);
        else passed++;
      end
      if (bus.busy === 1'b1 && !prev_busy) begin
        if (gi > 0) begin
          checks++;
          if (idle_run !== 1)
            $display("FAIL dead_cycle cycle %0d: got %0d idle cycles want 1", c, idle_run);
          else passed++;
        end
        cur_g = (gi < exp_g.size()) ? exp_g[gi] : -1;
        checks++;
        if (int'(bus.grant_id) !== cur_g)
          $display("FAIL grant_order burst %0d: got %0d want %0d", gi, bus.grant_id, cur_g);
        else passed++;
        gi++;
      end else if (bus.busy === 1'b1) begin
        checks++;
        if (int'(bus.grant_id) !== cur_g)
          $display("FAIL grant_held cycle %0d: got %0d want %0d", c, bus.grant_id, cur_g);
        else passed++;
      end
      idle_run = (bus.busy === 1'b1) ? 0 : idle_run + 1;
      prev_busy = (bus.busy === 1'b1);
      done = (exp_d.size() == 0);
      for (int i = 0; i < N; i++) if (hd[i] < tl[i]) done = 1'b0;
      if (done) begin
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL end_idle: got busy %b want 0", bus.busy);
        else passed++;
        checks++;
        if (gi !== exp_g.size()) $display("FAIL burst_count: got %0d want %0d", gi, exp_g.size());
        else passed++;
      end else begin
        af_b = ((c >= af_at) && (c < af_at + af_len)) || ($urandom_range(99) < af_pct);
        full_b = ($urandom_range(99) < full_pct);
        bus.fifo_almost_full = af_b;
        bus.fifo_wr_full = full_b;
        for (int i = 0; i < N; i++) begin
          has = (hd[i] < tl[i]);
          gap = (bus.busy === 1'b1) && (int'(bus.grant_id) == i) && ($urandom_range(99) < gap_pct);
          vld[i] = has && !gap;
          bus.req_data[i*W +: W] = has ? mem_d[i][hd[i]] : $urandom;
          bus.req_last[i] = has ? mem_l[i][hd[i]] : 1'($urandom_range(1));
        end
        bus.req_valid = vld;
        #1;
        rdy = bus.req_ready;
        checks++;
        if ($countones(rdy) > 1) $display("FAIL ready_onehot cycle %0d: got %b", c, rdy);
        else passed++;
        if (af_b || full_b) begin
          checks++;
          if (rdy !== '0) $display("FAIL ready_throttle cycle %0d: got %b want 0000", c, rdy);
          else passed++;
        end
        if (rdy !== '0) begin
          checks++;
          if (cur_g < 0 || rdy !== (N'(1) << cur_g))
            $display("FAIL ready_owner cycle %0d: got %b want grantee %0d", c, rdy, cur_g);
          else passed++;
        end
        for (int i = 0; i < N; i++) pend[i] = rdy[i] && vld[i];
      end
    end
    if (!done) begin
      checks++;
      $display("FAIL timeout: %0d writes still expected", exp_d.size());
    end
    bus.req_valid = '0;
    bus.fifo_almost_full = 1'b0;
    bus.fifo_wr_full = 1'b0;
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic check_stat_beats;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (stat_beats[i*32 +: 32] !== 32'(pops[i]))
        $display("FAIL stat_beats[%0d]: got %0d want %0d", i, stat_beats[i*32 +: 32], pops[i]);
      else passed++;
    end
  endtask
`endif

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 4'($urandom);
    bus.req_data = {$urandom, $urandom, $urandom, $urandom};
    bus.req_last = 4'($urandom);
    bus.fifo_almost_full = 1'b0;
    bus.fifo_wr_full = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== '0) $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    else passed++;
    checks++;
    if (bus.fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", bus.fifo_wr_en);
    else passed++;
    checks++;
    if (bus.fifo_wr_data !== '0) $display("FAIL reset_wr_data: got %h want 0", bus.fifo_wr_data);
    else passed++;
    checks++;
    if (bus.grant_id !== '0) $display("FAIL reset_grant: got %0d want 0", bus.grant_id);
    else passed++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else passed++;
`ifdef FIFO_ARB_STATS_EN
    checks++;
    if (stat_beats !== '0 || stall_cycles !== '0)
      $display("FAIL reset_stats: got %h/%0d want 0/0", stat_beats, stall_cycles);
    else passed++;
`endif
    apply_reset();
  endtask

  task automatic test_single;
    apply_reset();
    load_seq(0, 5, 5);
    run_traffic(0, 0, 0, -1, 0, 200);
  endtask

  task automatic test_round_robin;
    apply_reset();
    load_seq(0, 6, 3);
    for (int r = 1; r < N; r++) load_seq(r, 3, 3);
    run_traffic(0, 0, 0, -1, 0, 300);
`ifdef FIFO_ARB_STATS_EN
    check_stat_beats();
`endif
  endtask

  task automatic test_burst_max;
    apply_reset();
    load_seq(1, 40, 40);
    load_seq(0, 2, 2);
    load_seq(2, 4, 2);
    load_seq(3, 2, 2);
    run_traffic(0, 0, 0, -1, 0, 400);
  endtask

  task automatic test_almost_full;
    apply_reset();
    load_seq(0, 20, 20);
    load_seq(1, 3, 3);
    run_traffic(0, 0, 0, 4, 10, 400);
`ifdef FIFO_ARB_STATS_EN
    check_stat_beats();
    checks++;
    if (stall_cycles !== 32'd10) $display("FAIL stall_cycles: got %0d want 10", stall_cycles);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_burst;
    int beats1;
    bit sent0, hit, seen;
    logic [N-1:0] rdy;
    apply_reset();
    sent0 = 1'b0;
    beats1 = 0;
    hit = 1'b0;
    bus.req_data[0 +: W] = 32'h0000_0100;
    bus.req_data[W +: W] = 32'h0000_0200;
    bus.req_last = 4'b0001;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      bus.req_valid = {2'b00, 1'b1, !sent0};
      #1;
      rdy = bus.req_ready;
      if (rdy[0]) sent0 = 1'b1;
      if (rdy[1]) begin
        beats1++;
        if (beats1 == 3) hit = 1'b1;
      end
    end
    checks++;
    if (!hit) $display("FAIL rst_setup: got %0d req1 beats want 3", beats1);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.fifo_wr_en !== 1'b0) $display("FAIL rst_mid_wr_en: got %b want 0", bus.fifo_wr_en);
    else passed++;
    checks++;
    if (bus.busy !== 1'b0 || bus.grant_id !== '0)
      $display("FAIL rst_mid_state: got busy %b grant %0d want 0/0", bus.busy, bus.grant_id);
    else passed++;
    checks++;
    if (bus.req_ready !== '0 || bus.fifo_wr_data !== '0)
      $display("FAIL rst_mid_outputs: got ready %b data %h want 0/0", bus.req_ready, bus.fifo_wr_data);
    else passed++;
    bus.req_valid = 4'b0101;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      seen = (bus.busy === 1'b1);
    end
    checks++;
    if (!seen || bus.grant_id !== 2'd0)
      $display("FAIL rst_next_grant: got busy %b grant %0d want 1/0", bus.busy, bus.grant_id);
    else passed++;
    apply_reset();
  endtask

  task automatic test_random;
    int n;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      for (int r = 0; r < N; r++) begin
        n = $urandom_range(24);
        for (int k = 0; k < n; k++)
          push_word(r, $urandom, (k == n - 1) || ($urandom_range(3) == 0));
      end
      run_traffic(15, 5, 20, -1, 0, 3000);
`ifdef FIFO_ARB_STATS_EN
      check_stat_beats();
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_max();
    test_almost_full();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
